// File: rtl/forward_unit_nw.sv
// N-issue EX-stage operand forwarding with load-use stall detection and
// per-operand capture registers that keep retired values across stall cycles.
module forward_unit_nw #(
    parameter int ISSUE_W = 2,
    parameter int DATA_W  = 32,
    parameter int AW      = 5,
    parameter int CNT_W   = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ISSUE_W*2*AW-1:0]       ex_raddr,
    input  logic [ISSUE_W*2*DATA_W-1:0]   ex_rdata,
    input  logic                          ex_stall,
    input  logic                          ex_flush,
    input  logic [ISSUE_W-1:0]            mem_we,
    input  logic [ISSUE_W*AW-1:0]         mem_waddr,
    input  logic [ISSUE_W*DATA_W-1:0]     mem_alu_result,
    input  logic [ISSUE_W-1:0]            mem_ready,
    input  logic [ISSUE_W-1:0]            wb_we,
    input  logic [ISSUE_W*AW-1:0]         wb_waddr,
    input  logic [ISSUE_W*DATA_W-1:0]     wb_wdata,
    output logic [ISSUE_W*2*DATA_W-1:0]   ex_rdata_f,
    output logic                          fwd_stall,
    output logic [CNT_W-1:0]              stall_cnt
);

    localparam int NOPS = 2 * ISSUE_W;

    logic [DATA_W-1:0] hold_d [NOPS];
    logic [NOPS-1:0]   hold_v;
    logic [DATA_W-1:0] op_val [NOPS];
    logic [NOPS-1:0]   unres;

    function automatic logic hit(input logic we, input logic [AW-1:0] waddr,
                                 input logic [AW-1:0] raddr);
        return we && (waddr == raddr) && (raddr != '0);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    // Lanes are walked oldest to youngest so the youngest match wins; the
    // last matching MEM lane alone decides whether the operand is unresolved.
    always_comb begin
        unres = '0;
        for (int i = 0; i < NOPS; i++) begin
            op_val[i] = ex_rdata[i*DATA_W +: DATA_W];
            if (hold_v[i] && !rst)
                op_val[i] = hold_d[i];
            for (int j = 0; j < ISSUE_W; j++)
                if (hit(wb_we[j], wb_waddr[j*AW +: AW], ex_raddr[i*AW +: AW]))
                    op_val[i] = wb_wdata[j*DATA_W +: DATA_W];
            for (int j = 0; j < ISSUE_W; j++)
                if (hit(mem_we[j], mem_waddr[j*AW +: AW], ex_raddr[i*AW +: AW])) begin
                    unres[i] = !mem_ready[j];
                    if (mem_ready[j])
                        op_val[i] = mem_alu_result[j*DATA_W +: DATA_W];
                end
        end
    end

    for (genvar g = 0; g < NOPS; g++) begin : g_out
        assign ex_rdata_f[g*DATA_W +: DATA_W] = op_val[g];
    end

    assign fwd_stall = |unres;

    // Capture stage: valid bits are control and reset; data is not.
    always_ff @(posedge clk) begin
        if (rst || ex_flush) begin
            hold_v <= '0;
        end else if (ex_stall) begin
            for (int i = 0; i < NOPS; i++)
                if (!unres[i])
                    hold_v[i] <= 1'b1;
        end else begin
            hold_v <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (ex_stall) begin
            for (int i = 0; i < NOPS; i++)
                if (!unres[i])
                    hold_d[i] <= op_val[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if (fwd_stall)
            stall_cnt <= sat_inc(stall_cnt);
    end

endmodule

// File: tb/tb_forward_unit_nw.sv
// Directed self-checking bench for forward_unit_nw (ISSUE_W=2), with a second
// CNT_W=4 instance sharing the stimulus to exercise counter saturation.
module tb_forward_unit_nw;

    localparam int IW = 2;
    localparam int DW = 32;
    localparam int AW = 5;

    logic               clk = 1'b0;
    logic               rst;
    logic [IW*2*AW-1:0] ex_raddr;
    logic [IW*2*DW-1:0] ex_rdata;
    logic               ex_stall;
    logic               ex_flush;
    logic [IW-1:0]      mem_we;
    logic [IW*AW-1:0]   mem_waddr;
    logic [IW*DW-1:0]   mem_alu_result;
    logic [IW-1:0]      mem_ready;
    logic [IW-1:0]      wb_we;
    logic [IW*AW-1:0]   wb_waddr;
    logic [IW*DW-1:0]   wb_wdata;
    logic [IW*2*DW-1:0] ex_rdata_f;
    logic               fwd_stall;
    logic [31:0]        stall_cnt;
    logic [IW*2*DW-1:0] sat_rdata_f;
    logic               sat_fwd_stall;
    logic [3:0]         sat_stall_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    forward_unit_nw #(.ISSUE_W(IW), .DATA_W(DW), .AW(AW), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .ex_raddr(ex_raddr), .ex_rdata(ex_rdata),
        .ex_stall(ex_stall), .ex_flush(ex_flush), .mem_we(mem_we),
        .mem_waddr(mem_waddr), .mem_alu_result(mem_alu_result),
        .mem_ready(mem_ready), .wb_we(wb_we), .wb_waddr(wb_waddr),
        .wb_wdata(wb_wdata), .ex_rdata_f(ex_rdata_f), .fwd_stall(fwd_stall),
        .stall_cnt(stall_cnt)
    );

    forward_unit_nw #(.ISSUE_W(IW), .DATA_W(DW), .AW(AW), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .ex_raddr(ex_raddr), .ex_rdata(ex_rdata),
        .ex_stall(ex_stall), .ex_flush(ex_flush), .mem_we(mem_we),
        .mem_waddr(mem_waddr), .mem_alu_result(mem_alu_result),
        .mem_ready(mem_ready), .wb_we(wb_we), .wb_waddr(wb_waddr),
        .wb_wdata(wb_wdata), .ex_rdata_f(sat_rdata_f), .fwd_stall(sat_fwd_stall),
        .stall_cnt(sat_stall_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ex_raddr = '0; ex_rdata = '0; ex_stall = 1'b0; ex_flush = 1'b0;
        mem_we = '0; mem_waddr = '0; mem_alu_result = '0; mem_ready = '0;
        wb_we = '0; wb_waddr = '0; wb_wdata = '0;
    endtask

    task automatic set_op(input int lane, input int op, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
        ex_raddr[(2*lane+op)*AW +: AW] = a;
        ex_rdata[(2*lane+op)*DW +: DW] = d;
    endtask

    task automatic set_mem(input int lane, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic rdy);
        mem_we[lane] = we;
        mem_waddr[lane*AW +: AW] = a;
        mem_alu_result[lane*DW +: DW] = d;
        mem_ready[lane] = rdy;
    endtask

    task automatic set_wb(input int lane, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
        wb_we[lane] = we;
        wb_waddr[lane*AW +: AW] = a;
        wb_wdata[lane*DW +: DW] = d;
    endtask

    function automatic logic [DW-1:0] f(input int lane, input int op);
        return ex_rdata_f[(2*lane+op)*DW +: DW];
    endfunction

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        step();
        checks++;
        if (stall_cnt !== 32'd0) begin
            errors++; $display("FAIL reset_cnt got %0d expected 0", stall_cnt);
        end
        rst = 1'b0;
        set_op(0, 1, 5'd3, 32'h5);
        #1;
        checks++;
        if (f(0, 1) !== 32'h5) begin
            errors++; $display("FAIL reset_passthru got %h expected 00000005", f(0, 1));
        end
        checks++;
        if (fwd_stall !== 1'b0) begin
            errors++; $display("FAIL reset_stall got %b expected 0", fwd_stall);
        end
    endtask

    task automatic test_priority();
        clear_inputs();
        step();
        set_op(0, 0, 5'd3, 32'h1);
        set_mem(0, 1'b1, 5'd3, 32'h11, 1'b1);
        set_mem(1, 1'b1, 5'd3, 32'h22, 1'b1);
        set_wb(1, 1'b1, 5'd3, 32'h33);
        #1;
        checks++;
        if (f(0, 0) !== 32'h22 || fwd_stall !== 1'b0) begin
            errors++; $display("FAIL prio_mem1 got %h/%b expected 00000022/0", f(0, 0), fwd_stall);
        end
        set_mem(1, 1'b0, 5'd3, 32'h22, 1'b1);
        #1;
        checks++;
        if (f(0, 0) !== 32'h11) begin
            errors++; $display("FAIL prio_mem0 got %h expected 00000011", f(0, 0));
        end
        set_mem(0, 1'b0, 5'd3, 32'h11, 1'b1);
        set_wb(0, 1'b1, 5'd3, 32'h44);
        #1;
        checks++;
        if (f(0, 0) !== 32'h33) begin
            errors++; $display("FAIL prio_wb1 got %h expected 00000033", f(0, 0));
        end
        set_wb(1, 1'b0, 5'd3, 32'h33);
        #1;
        checks++;
        if (f(0, 0) !== 32'h44) begin
            errors++; $display("FAIL prio_wb0 got %h expected 00000044", f(0, 0));
        end
        set_wb(0, 1'b1, 5'd9, 32'h44);
        #1;
        checks++;
        if (f(0, 0) !== 32'h1) begin
            errors++; $display("FAIL prio_nomatch got %h expected 00000001", f(0, 0));
        end
    endtask

    task automatic test_zero();
        clear_inputs();
        step();
        set_op(0, 0, 5'd0, 32'h0);
        set_mem(1, 1'b1, 5'd0, 32'hFF, 1'b1);
        set_wb(0, 1'b1, 5'd0, 32'hEE);
        #1;
        checks++;
        if (f(0, 0) !== 32'h0 || fwd_stall !== 1'b0) begin
            errors++; $display("FAIL zero_reg got %h/%b expected 00000000/0", f(0, 0), fwd_stall);
        end
        set_mem(1, 1'b1, 5'd0, 32'hFF, 1'b0);
        #1;
        checks++;
        if (f(0, 0) !== 32'h0 || fwd_stall !== 1'b0) begin
            errors++; $display("FAIL zero_notready got %h/%b expected 00000000/0", f(0, 0), fwd_stall);
        end
    endtask

    task automatic test_load_use();
        clear_inputs();
        step();
        set_mem(0, 1'b1, 5'd7, 32'hDEAD, 1'b0);
        set_op(1, 1, 5'd7, 32'h0);
        ex_stall = 1'b1;
        #1;
        checks++;
        if (fwd_stall !== 1'b1) begin
            errors++; $display("FAIL lu_stall got %b expected 1", fwd_stall);
        end
        step();
        checks++;
        if (stall_cnt !== 32'd1) begin
            errors++; $display("FAIL lu_cnt got %0d expected 1", stall_cnt);
        end
        set_mem(0, 1'b0, 5'd0, 32'h0, 1'b0);
        set_wb(0, 1'b1, 5'd7, 32'hABCD);
        ex_stall = 1'b0;
        #1;
        checks++;
        if (f(1, 1) !== 32'hABCD || fwd_stall !== 1'b0) begin
            errors++; $display("FAIL lu_wb got %h/%b expected 0000abcd/0", f(1, 1), fwd_stall);
        end
        step();
        checks++;
        if (stall_cnt !== 32'd1) begin
            errors++; $display("FAIL lu_cnt_hold got %0d expected 1", stall_cnt);
        end
    endtask

    task automatic test_shadow();
        clear_inputs();
        step();
        set_op(1, 1, 5'd7, 32'h0);
        set_mem(0, 1'b1, 5'd7, 32'h77, 1'b0);
        set_mem(1, 1'b1, 5'd7, 32'h55, 1'b1);
        #1;
        checks++;
        if (f(1, 1) !== 32'h55 || fwd_stall !== 1'b0) begin
            errors++; $display("FAIL shadow got %h/%b expected 00000055/0", f(1, 1), fwd_stall);
        end
        set_mem(0, 1'b1, 5'd7, 32'h55, 1'b1);
        set_mem(1, 1'b1, 5'd7, 32'h77, 1'b0);
        #1;
        checks++;
        if (fwd_stall !== 1'b1) begin
            errors++; $display("FAIL young_notready got %b expected 1", fwd_stall);
        end
        clear_inputs();
    endtask

    task automatic test_stall_capture();
        clear_inputs();
        step();
        set_op(0, 0, 5'd4, 32'h0);
        ex_stall = 1'b1;
        set_wb(0, 1'b1, 5'd4, 32'h99);
        #1;
        checks++;
        if (f(0, 0) !== 32'h99) begin
            errors++; $display("FAIL cap_t got %h expected 00000099", f(0, 0));
        end
        step();
        set_wb(0, 1'b0, 5'd0, 32'h0);
        #1;
        checks++;
        if (f(0, 0) !== 32'h99) begin
            errors++; $display("FAIL cap_t1 got %h expected 00000099", f(0, 0));
        end
        step();
        ex_stall = 1'b0;
        #1;
        checks++;
        if (f(0, 0) !== 32'h99) begin
            errors++; $display("FAIL cap_t2 got %h expected 00000099", f(0, 0));
        end
        step();
        set_op(0, 0, 5'd4, 32'h12);
        #1;
        checks++;
        if (f(0, 0) !== 32'h12) begin
            errors++; $display("FAIL cap_newbundle got %h expected 00000012", f(0, 0));
        end
    endtask

    task automatic test_flush();
        clear_inputs();
        step();
        set_op(0, 0, 5'd4, 32'h0);
        ex_stall = 1'b1;
        set_wb(0, 1'b1, 5'd4, 32'h99);
        step();
        set_wb(0, 1'b0, 5'd0, 32'h0);
        set_op(0, 0, 5'd4, 32'h21);
        ex_flush = 1'b1;
        #1;
        checks++;
        if (f(0, 0) !== 32'h99) begin
            errors++; $display("FAIL flush_before got %h expected 00000099", f(0, 0));
        end
        step();
        ex_flush = 1'b0;
        #1;
        checks++;
        if (f(0, 0) !== 32'h21) begin
            errors++; $display("FAIL flush_after got %h expected 00000021", f(0, 0));
        end
        ex_stall = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_stall();
        clear_inputs();
        step();
        set_op(0, 0, 5'd4, 32'h0);
        ex_stall = 1'b1;
        set_wb(0, 1'b1, 5'd4, 32'h99);
        step();
        set_wb(0, 1'b0, 5'd0, 32'h0);
        set_op(0, 0, 5'd4, 32'h21);
        rst = 1'b1;
        #1;
        checks++;
        if (f(0, 0) !== 32'h21) begin
            errors++; $display("FAIL rst_ignores_hold got %h expected 00000021", f(0, 0));
        end
        step();
        rst = 1'b0;
        #1;
        checks++;
        if (f(0, 0) !== 32'h21) begin
            errors++; $display("FAIL rst_cleared_hold got %h expected 00000021", f(0, 0));
        end
        ex_stall = 1'b0;
        step();
    endtask

    task automatic test_saturation();
        clear_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_mem(0, 1'b1, 5'd7, 32'h0, 1'b0);
        set_op(1, 1, 5'd7, 32'h0);
        for (int n = 0; n < 15; n++) step();
        checks++;
        if (sat_stall_cnt !== 4'hF || stall_cnt !== 32'd15) begin
            errors++; $display("FAIL sat_reach got %h/%0d expected f/15", sat_stall_cnt, stall_cnt);
        end
        for (int n = 0; n < 3; n++) step();
        checks++;
        if (sat_stall_cnt !== 4'hF) begin
            errors++; $display("FAIL sat_hold got %h expected f", sat_stall_cnt);
        end
        checks++;
        if (stall_cnt !== 32'd18) begin
            errors++; $display("FAIL cnt_wide got %0d expected 18", stall_cnt);
        end
        clear_inputs();
        step();
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_priority();
        test_zero();
        test_load_use();
        test_shadow();
        test_stall_capture();
        test_flush();
        test_reset_mid_stall();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/forward_unit_nw.md
Name: forward_unit_nw

Overview:
- Parametrised N-issue operand forwarding unit for the EX stage.
- Resolves each EX operand against MEM-stage ALU results and WB-stage write data.
- Detects load-use / long-latency dependences on MEM producers whose result is not yet available, and raises a stall.
- Keeps per-operand capture registers, so an EX bundle held across stall cycles does not lose values that retired to the register file while it waited.

Parameters:
- ISSUE_W, 2: issue lanes; lane ISSUE_W-1 is the youngest in a bundle.
- DATA_W, 32: register data width.
- AW, 5: register address width; address 0 is hard-wired zero.
- CNT_W, 32: stall performance counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- ex_raddr  in  ISSUE_W*2*AW  operand addresses. Operand k (0/1) of lane l is at slice (2l+k)*AW.
- ex_rdata  in  ISSUE_W*2*DATA_W  register-file operand values, same indexing.
- ex_stall  in  1  EX bundle held this cycle (global stall, including fwd_stall).
- ex_flush  in  1  EX bundle killed.
- mem_we  in  ISSUE_W  MEM lane write enable.
- mem_waddr  in  ISSUE_W*AW  MEM lane destination.
- mem_alu_result  in  ISSUE_W*DATA_W  MEM lane ALU result.
- mem_ready  in  ISSUE_W  1 means mem_alu_result is the final value; 0 means load/mul/div, value not yet available.
- wb_we  in  ISSUE_W  WB lane write enable.
- wb_waddr  in  ISSUE_W*AW  WB lane destination.
- wb_wdata  in  ISSUE_W*DATA_W  WB lane write data.
- ex_rdata_f  out  ISSUE_W*2*DATA_W  forwarded operands.
- fwd_stall  out  1  unresolved dependence on a not-ready MEM producer.
- stall_cnt  out  CNT_W  count of fwd_stall cycles.

Behaviour:
- Match rule: source s matches operand o iff s.we=1, s.waddr==o.raddr, and o.raddr!=0.
- Operand value priority, highest first:
  - MEM lanes, index ISSUE_W-1 down to 0;
  - WB lanes, index ISSUE_W-1 down to 0;
  - capture register, if hold_v=1;
  - ex_rdata.
- raddr==0 always yields ex_rdata, with no match and no stall.
- ex_rdata_f and fwd_stall are combinational: zero-latency, same cycle.
- Not-ready MEM producer:
  - If the highest-priority matching MEM lane has mem_ready=0, the operand is unresolved.
  - fwd_stall = OR over all operands of unresolved.
  - An unresolved operand's ex_rdata_f value is don't-care. Drive the lower-priority selection; do not drive X.
  - A younger MEM lane that matches with mem_ready=1 shadows an older not-ready lane: no stall.
- Capture registers: one hold_v/hold_d pair per operand, 2*ISSUE_W pairs.
  - rst=1 or ex_flush=1: all hold_v<=0. Flush wins over stall.
  - Else ex_stall=1: for each operand that is not unresolved, hold_d<=ex_rdata_f and hold_v<=1. Unresolved operands keep their hold state.
  - Else (bundle advances): all hold_v<=0.
  - A new bundle therefore never sees the previous bundle's hold.
- stall_cnt:
  - Reset to 0.
  - Increments by 1 on each cycle with fwd_stall=1 and rst=0.
  - Saturates at all-ones; no wrap.
- Reset values: stall_cnt=0, all hold_v=0.
- Outputs during reset follow the combinational rules, with hold ignored.
- Reset asserted mid-stall discards captured values.
- Intra-bundle dependences (lane l reading lane j<l's destination in the same EX bundle) are excluded by issue logic and are not handled here.

Test Plan:
- ISSUE_W=2. Lane0 op0 raddr=3. MEM lane0 and lane1 both write r3, values 0x11/0x22, ready=1. WB lane1 writes r3=0x33 -> ex_rdata_f=0x22, fwd_stall=0.
- raddr=0. MEM lane1 we=1, waddr=0, value 0xFF -> ex_rdata_f=ex_rdata (0x0). No stall.
- Load-use: MEM lane0 writes r7, ready=0; lane1 op1 raddr=7 -> fwd_stall=1 and stall_cnt +1. Next cycle the load sits in WB with wdata 0xABCD -> ex_rdata_f=0xABCD, fwd_stall=0.
- Shadowing: MEM lane0 r7 ready=0, MEM lane1 r7 ready=1 value 0x55 -> fwd_stall=0, operand=0x55.
- Stall capture:
  - Cycle t: ex_stall=1, WB writes r4=0x99.
  - Cycle t+1: ex_stall=1, no sources match, ex_rdata stale 0x0 -> operand=0x99.
  - Cycle t+2: ex_stall=0, then a new bundle with r4, no match -> ex_rdata.
- Flush and reset during stall clear hold_v; the next cycle uses ex_rdata. Hold stall_cnt at all-ones with CNT_W=4 for 3 stall cycles -> stays 0xF.
